// File: rtl/lpc_pkg.sv
// lpc_pkg: shared LPC target definitions (FSM states, cycle types, bus constants)
package lpc_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CYCTYPE,
        ST_ADDR,
        ST_WDATA,
        ST_HTAR,
        ST_SYNC,
        ST_RDATA,
        ST_PTAR
    } lpc_state_e;
    localparam logic [2:0] CYC_IO_RD  = 3'b000;
    localparam logic [2:0] CYC_IO_WR  = 3'b001;
    localparam logic [3:0] SYNC_READY = 4'h0;
    localparam logic [3:0] START      = 4'h0;
    localparam logic [3:0] LAD_IDLE   = 4'hF;
endpackage

// File: rtl/lpc_bios_wd_target_if.sv
// lpc_bios_wd_target_if: LPC pad-side bus bundle
//   LFRAMEn : frame, active low (host -> target)
//   LadIn   : LAD nibble sampled from pad (host -> target)
//   LadOut  : LAD nibble driven to pad (target -> host)
//   LadOe   : 1 = target drives LAD (target -> host)
interface lpc_bios_wd_target_if;
    logic       LFRAMEn;
    logic [3:0] LadIn;
    logic [3:0] LadOut;
    logic       LadOe;
    modport slave (input LFRAMEn, LadIn, output LadOut, LadOe);
    modport master(output LFRAMEn, LadIn, input LadOut, LadOe);
endinterface

// File: rtl/lpc_bios_wd_target.sv
// lpc_bios_wd_target: LPC I/O target holding the BIOS watchdog control register
//   LpcClock     : LPC clock, the only clock
//   MainReset    : asynchronous active-low reset
//   lpc          : LPC bus (LFRAMEn, LadIn, LadOut, LadOe)
//   BiosFinished : status bit0 at BASE_ADDR+1
//   BiosPowerOff : status bit1 at BASE_ADDR+1
//   ForceSwap    : status bit2 at BASE_ADDR+1
//   BiosRegister : last byte written to BASE_ADDR
//   BiosWrStrobe : one-cycle pulse on every BASE_ADDR write
module lpc_bios_wd_target
    import lpc_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0A00,
    parameter logic [7:0]  RST_VALUE = 8'h00
) (
    input  logic                        LpcClock,
    input  logic                        MainReset,
    lpc_bios_wd_target_if.slave         lpc,
    input  logic                        BiosFinished,
    input  logic                        BiosPowerOff,
    input  logic                        ForceSwap,
    output logic [7:0]                  BiosRegister,
    output logic                        BiosWrStrobe
);
    localparam logic [15:0] STATUS_ADDR = BASE_ADDR + 16'd1;

    lpc_state_e state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic        sel_q, sel_d;
    logic [11:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  bios_q, bios_d;
    logic        strobe_q, strobe_d;
    logic [15:0] addr_full;
    logic [7:0]  status;

    // The first three address nibbles are held; the fourth is taken straight off the bus.
    assign addr_full = {addr_q, lpc.LadIn};
    assign status    = {5'b0, ForceSwap, BiosPowerOff, BiosFinished};

    always_ff @(posedge LpcClock or negedge MainReset) begin
        if (!MainReset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 2'd0;
            wr_q     <= 1'b0;
            sel_q    <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            bios_q   <= RST_VALUE;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            bios_q   <= bios_d;
            strobe_q <= strobe_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        data_d   = data_q;
        bios_d   = bios_q;
        strobe_d = 1'b0;
        if (!lpc.LFRAMEn) begin
            // A low frame restarts or aborts from any state.
            state_d = (lpc.LadIn == START) ? ST_CYCTYPE : ST_IDLE;
            cnt_d   = 2'd0;
        end else begin
            case (state_q)
                ST_CYCTYPE: begin
                    wr_d    = lpc.LadIn[1];
                    state_d = (lpc.LadIn[3:1] == CYC_IO_RD || lpc.LadIn[3:1] == CYC_IO_WR) ? ST_ADDR : ST_IDLE;
                end
                ST_ADDR: begin
                    addr_d = {addr_q[7:0], lpc.LadIn};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        sel_d   = (addr_full == STATUS_ADDR);
                        data_d  = sel_d ? status : bios_q;
                        state_d = (addr_full == BASE_ADDR || sel_d) ? (wr_q ? ST_WDATA : ST_HTAR) : ST_IDLE;
                    end
                end
                ST_WDATA: begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q[0]) begin
                        data_d   = {lpc.LadIn, data_q[3:0]};
                        bios_d   = sel_q ? bios_q : data_d;
                        strobe_d = !sel_q;
                        state_d  = ST_HTAR;
                        cnt_d    = 2'd0;
                    end else begin
                        data_d[3:0] = lpc.LadIn;
                    end
                end
                ST_HTAR: begin
                    cnt_d   = cnt_q[0] ? 2'd0 : cnt_q + 2'd1;
                    state_d = cnt_q[0] ? ST_SYNC : ST_HTAR;
                end
                ST_SYNC: state_d = wr_q ? ST_PTAR : ST_RDATA;
                ST_RDATA: begin
                    cnt_d   = cnt_q[0] ? 2'd0 : cnt_q + 2'd1;
                    state_d = cnt_q[0] ? ST_PTAR : ST_RDATA;
                end
                ST_PTAR: begin
                    cnt_d   = cnt_q[0] ? 2'd0 : cnt_q + 2'd1;
                    state_d = cnt_q[0] ? ST_IDLE : ST_PTAR;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode straight from state so reset releases the bus immediately.
    assign lpc.LadOe  = (state_q == ST_SYNC) || (state_q == ST_RDATA) || (state_q == ST_PTAR && !cnt_q[0]);
    assign lpc.LadOut = (state_q == ST_SYNC)  ? SYNC_READY :
                        (state_q == ST_RDATA) ? (cnt_q[0] ? data_q[7:4] : data_q[3:0]) : LAD_IDLE;
    assign BiosRegister = bios_q;
    assign BiosWrStrobe = strobe_q;
endmodule

// File: tb/tb_lpc_bios_wd_target.sv
// tb_lpc_bios_wd_target: scoreboard bench for the LPC BIOS watchdog target
module tb_lpc_bios_wd_target;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       fs, po, bf;
    logic [7:0] bios;
    logic       stb;
    int         checks = 0;
    int         errors = 0;
    logic [3:0] lad_q[$];
    logic [7:0] stb_q[$];

    lpc_bios_wd_target_if bus();

    lpc_bios_wd_target dut (
        .LpcClock    (clk),
        .MainReset   (rst_n),
        .lpc         (bus),
        .BiosFinished(bf),
        .BiosPowerOff(po),
        .ForceSwap   (fs),
        .BiosRegister(bios),
        .BiosWrStrobe(stb)
    );

    always #5 clk = ~clk;

    // Monitor: every driven nibble and every strobe must match the next queued expectation.
    always @(negedge clk) begin : monitor
        logic [3:0] el;
        logic [7:0] eb;
        if (rst_n) begin
            if (bus.LadOe) begin
                checks++;
                if (lad_q.size() == 0) begin
                    errors++;
                    $display("FAIL lad_drive: LadOut=%h driven, required no drive", bus.LadOut);
                end else begin
                    el = lad_q.pop_front();
                    if (bus.LadOut !== el) begin
                        errors++;
                        $display("FAIL lad_nibble: got %h expected %h", bus.LadOut, el);
                    end
                end
            end
            if (stb) begin
                checks++;
                if (stb_q.size() == 0) begin
                    errors++;
                    $display("FAIL strobe: unexpected strobe with BiosRegister=%h", bios);
                end else begin
                    eb = stb_q.pop_front();
                    if (bios !== eb) begin
                        errors++;
                        $display("FAIL strobe_value: got %h expected %h", bios, eb);
                    end
                end
            end
        end
    end

    task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic drive(input logic f, input logic [3:0] d);
        bus.LFRAMEn = f;
        bus.LadIn   = d;
        @(posedge clk);
        #2;
    endtask

    task automatic hdr(input logic [3:0] cyc, input logic [15:0] a);
        drive(1'b0, 4'h0);
        drive(1'b1, cyc);
        for (int i = 3; i >= 0; i--) drive(1'b1, a[4*i +: 4]);
    endtask

    task automatic wr(input logic [3:0] cyc, input logic [15:0] a, input logic [7:0] d,
                      input bit sync, input bit strobe, input bit abort);
        if (sync) begin
            lad_q.push_back(4'h0);
            lad_q.push_back(4'hF);
        end
        if (strobe) stb_q.push_back(d);
        hdr(cyc, a);
        drive(1'b1, d[3:0]);
        if (abort) begin
            drive(1'b0, 4'hF);
            repeat (2) drive(1'b1, 4'hF);
        end else begin
            drive(1'b1, d[7:4]);
            repeat (5) drive(1'b1, 4'hF);
        end
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] exp, input bit sync, input bit rst_in_sync);
        if (sync && !rst_in_sync) begin
            lad_q.push_back(4'h0);
            lad_q.push_back(exp[3:0]);
            lad_q.push_back(exp[7:4]);
            lad_q.push_back(4'hF);
        end
        hdr(4'h0, a);
        if (rst_in_sync) begin
            repeat (2) drive(1'b1, 4'hF);
            rst_n = 1'b0;
            #1;
            chk("rst_sync_oe", {7'b0, bus.LadOe}, 8'h00);
            chk("rst_sync_bios", bios, 8'h00);
            repeat (2) @(posedge clk);
            #2;
            rst_n = 1'b1;
        end else begin
            repeat (7) drive(1'b1, 4'hF);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        bus.LFRAMEn = 1'b1;
        bus.LadIn = 4'hF;
        fs = 1'b0;
        po = 1'b0;
        bf = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_oe", {7'b0, bus.LadOe}, 8'h00);
        chk("reset_ladout", {4'h0, bus.LadOut}, 8'h0F);
        chk("reset_bios", bios, 8'h00);
        chk("reset_strobe", {7'b0, stb}, 8'h00);
        rst_n = 1'b1;
        drive(1'b1, 4'hF);
        wr(4'h2, 16'h0A00, 8'hAA, 1, 1, 0);
        chk("write_aa", bios, 8'hAA);
        wr(4'h2, 16'h0A00, 8'h55, 1, 1, 0);
        rd(16'h0A00, 8'h55, 1, 0);
        chk("read_no_clear", bios, 8'h55);
        fs = 1'b1;
        bf = 1'b1;
        rd(16'h0A01, 8'h05, 1, 0);
        wr(4'h2, 16'h0A01, 8'h33, 1, 0, 0);
        chk("status_write_ignored", bios, 8'h55);
        wr(4'h2, 16'h0A08, 8'h29, 0, 0, 0);
        wr(4'h6, 16'h0A00, 8'h29, 0, 0, 0);
        wr(4'h4, 16'h0A00, 8'h29, 0, 0, 0);
        rd(16'h0B00, 8'h00, 0, 0);
        chk("miss_unchanged", bios, 8'h55);
        wr(4'h2, 16'h0A00, 8'hFF, 0, 0, 1);
        chk("abort_unchanged", bios, 8'h55);
        drive(1'b0, 4'hF);
        drive(1'b0, 4'h3);
        wr(4'h2, 16'h0A00, 8'hFF, 1, 1, 0);
        chk("write_ff", bios, 8'hFF);
        wr(4'h2, 16'h0A00, 8'hFF, 1, 1, 0);
        chk("rewrite_ff", bios, 8'hFF);
        rd(16'h0A00, 8'h00, 1, 1);
        wr(4'h2, 16'h0A00, 8'h29, 1, 1, 0);
        chk("post_reset_write", bios, 8'h29);
        rd(16'h0A00, 8'h29, 1, 0);
        repeat (3) drive(1'b1, 4'hF);
        chk("lad_queue_empty", 8'(lad_q.size()), 8'h00);
        chk("strobe_queue_empty", 8'(stb_q.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
